perf_counter_sample_ctrl: RTL and testbench
===========================================

Name: perf_counter_sample_ctrl

Overview:
- Sequences the performance event counter bank into fixed sampling windows.
- Each window ends on an interval timeout or a software trigger. At that point the block snapshots all counters, pulses a clear to the bank and streams the snapshot out over a valid/ready interface as one header beat plus one beat per event.
- Sits between the counter bank and the AXI-stream/DMA packer.

Parameters:
- NUM_EVENTS, 115, number of event counters in the bank.
- COUNTER_WIDTH, 7, width of each counter.
- OUT_WIDTH, 32, output beat width; must be >= 1+IDX_W+COUNTER_WIDTH and >= 25.
- IDX_W (localparam), $clog2(NUM_EVENTS), event index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- enable  in  1  level; 1 = sampling active.
- interval  in  32  window length in cycles; 0 = timer off, trigger-only.
- sw_trigger  in  1  single-cycle pulse; ends the current window early.
- counters_flat  in  NUM_EVENTS*COUNTER_WIDTH  packed bank values; event i at bits [i*CW +: CW].
- counter_clear  out  1  one-cycle pulse to the bank.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  OUT_WIDTH  beat payload.
- out_last  out  1  final beat of a packet.
- busy  out  1  packet transmission in progress.
- dropped_count  out  8  saturating count of discarded windows.

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. While reset is asserted:
  - all outputs = 0; state = IDLE; timer = 0; seq = 0; dropped_count = 0; snapshot register = 0.
  - Reset mid-packet aborts the packet without completing it.
- Bank contract: counter_clear makes the bank's next value equal the current event bit, so no event is lost on a clear.
- State IDLE:
  - enable=1 -> COUNT and pulse counter_clear in the same cycle, so every window starts from zero.
- State COUNT:
  - timer increments every cycle.
  - Window end = (interval != 0 && timer == interval-1) || sw_trigger.
  - On window end: latch counters_flat into the snapshot register, pulse counter_clear, reset timer to 0, go to SEND_HDR. Latency from window end to out_valid = 1 cycle.
  - If enable deasserts in COUNT -> IDLE. No packet is sent and no clear is issued.
- Counting continues during transmission: the timer runs and triggers are evaluated in SEND_HDR/SEND_DATA too.
  - A window end during transmission = drop: pulse counter_clear, reset timer, dropped_count += 1 saturating at 255. The snapshot register is not overwritten.
- State SEND_HDR: out_valid=1, out_data = {1'b1, seq[15:0], dropped_count[7:0]}, zero-extended at the MSBs.
  - On out_valid&&out_ready: seq += 1 (wraps at 16 bits), idx = 0 -> SEND_DATA.
- State SEND_DATA: out_valid=1, out_data = {1'b0, idx, snapshot[idx]}, zero-extended.
  - out_last = (idx == NUM_EVENTS-1).
  - Each handshake increments idx. The handshake on the last beat -> COUNT if enable, else IDLE.
  - dropped_count is not cleared by sending; it is a cumulative status.
- Handshake rules:
  - Once out_valid is asserted, out_data/out_last stay stable until the handshake.
  - out_valid never deasserts without a handshake, except on reset.
- busy = 1 in SEND_HDR and SEND_DATA.
- If enable deasserts mid-packet, the packet completes, then the block goes to IDLE. Window ends after the deassert are ignored.
- Simultaneous timeout and sw_trigger in the same cycle count as one window end.
- sw_trigger in IDLE is ignored.

Decomposition:
- Package perf_sample_pkg holds:
  - state enum: IDLE, COUNT, SEND_HDR, SEND_DATA;
  - header flag bit position and field widths (SEQ_W=16, DROP_W=8).
- One sub-module, perf_sample_serializer: snapshot register plus the idx-driven beat mux with valid/ready/last.
- Top level keeps the timer, state machine, seq and drop logic.

Test Plan:
- Interval timeout:
  - Stimulus: interval=10, enable=1, all counters static at 3, out_ready=1.
  - Required: counter_clear on cycles 0 and 10; header seq=0, drop=0; 115 data beats of value 3, idx 0..114; out_last only on idx 114.
- Software trigger, timer off:
  - Stimulus: interval=0, sw_trigger pulse at cycle 5.
  - Required: exactly one packet. With no further trigger, no second packet for 1000 cycles.
- Backpressure:
  - Stimulus: out_ready toggles 1/0 randomly.
  - Required: out_data stable while valid&&!ready; all 116 beats are delivered in order.
- Drop:
  - Stimulus: interval=20, out_ready=0 for 50 cycles.
  - Required: dropped_count=2; the pending packet still carries the first snapshot. The next header reports drop=2.
- Saturation and wrap:
  - Force 300 drops -> dropped_count=255.
  - Force seq to 16'hFFFF -> the next header shows 0.
- Enable low mid-packet, then reset:
  - Stimulus: deassert enable during beat 40.
  - Required: the packet finishes, then the block goes to IDLE with no clear.
  - rst_n low mid-packet -> out_valid=0 immediately and all outputs at reset values.

Source files
------------

// File: rtl/perf_sample_pkg.sv
// Shared types and field widths for the performance counter sampling controller.
package perf_sample_pkg;

  localparam int unsigned SEQ_W        = 16;
  localparam int unsigned DROP_W       = 8;
  // The header flag sits just above the seq and drop fields.
  localparam int unsigned HDR_FLAG_POS = SEQ_W + DROP_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNT     = 2'd1,
    SEND_HDR  = 2'd2,
    SEND_DATA = 2'd3
  } state_e;

  // Header beat payload, placed at the LSBs of the output beat.
  typedef struct packed {
    logic              flag;
    logic [SEQ_W-1:0]  seq;
    logic [DROP_W-1:0] drop;
  } hdr_t;

endpackage

// File: rtl/perf_sample_serializer.sv
// Snapshot register plus the header/data beat sequencer on a valid/ready port.
module perf_sample_serializer
  import perf_sample_pkg::*;
#(
  parameter int unsigned NUM_EVENTS    = 115,
  parameter int unsigned COUNTER_WIDTH = 7,
  parameter int unsigned OUT_WIDTH     = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                load,
  input  hdr_t                                hdr,
  input  logic [NUM_EVENTS*COUNTER_WIDTH-1:0] counters_flat,
  input  logic                                out_ready,
  output logic                                out_valid,
  output logic [OUT_WIDTH-1:0]                out_data,
  output logic                                out_last
);

  localparam int unsigned IDX_W = $clog2(NUM_EVENTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVENTS - 1);

  // Reject parameter sets whose beats would not fit the output width.
  if ((OUT_WIDTH < HDR_FLAG_POS + 1) || (OUT_WIDTH < 1 + IDX_W + COUNTER_WIDTH)) begin : g_bad_width
    $error("perf_sample_serializer: OUT_WIDTH too narrow for header or data beat");
  end

  logic [COUNTER_WIDTH-1:0] bank [NUM_EVENTS];
  logic [COUNTER_WIDTH-1:0] snap_q [NUM_EVENTS];
  logic [IDX_W-1:0]         idx_q;
  logic [IDX_W-1:0]         idx_nxt;
  logic                     hdr_phase_q;
  logic                     hs;

  // Unpack the flat counter bus into per-event lanes.
  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_unpack
    assign bank[g] = counters_flat[g*COUNTER_WIDTH +: COUNTER_WIDTH];
  end

  assign hs      = out_valid && out_ready;
  assign idx_nxt = hdr_phase_q ? '0 : idx_q + IDX_W'(1);

  // Capture the whole bank at window end; held until the next accepted window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '{default: '0};
    end else if (load) begin
      snap_q <= bank;
    end
  end

  // Beat register: header first, then one data beat per event, advanced per handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      idx_q       <= '0;
      hdr_phase_q <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_data    <= OUT_WIDTH'(hdr);
      out_last    <= 1'b0;
      idx_q       <= '0;
      hdr_phase_q <= 1'b1;
    end else if (hs) begin
      hdr_phase_q <= 1'b0;
      if (out_last) begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_last  <= 1'b0;
      end else begin
        idx_q    <= idx_nxt;
        out_data <= OUT_WIDTH'({1'b0, idx_nxt, snap_q[idx_nxt]});
        out_last <= (idx_nxt == LAST_IDX);
      end
    end
  end

endmodule

// File: rtl/perf_counter_sample_ctrl.sv
// Windows the event counter bank, snapshots it and streams it as header + data beats.
module perf_counter_sample_ctrl
  import perf_sample_pkg::*;
#(
  parameter int unsigned NUM_EVENTS    = 115,
  parameter int unsigned COUNTER_WIDTH = 7,
  parameter int unsigned OUT_WIDTH     = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic [31:0]                         interval,
  input  logic                                sw_trigger,
  input  logic [NUM_EVENTS*COUNTER_WIDTH-1:0] counters_flat,
  output logic                                counter_clear,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_WIDTH-1:0]                out_data,
  output logic                                out_last,
  output logic                                busy,
  output logic [7:0]                          dropped_count
);

  state_e            state_q, state_d;
  logic [31:0]       timer_q, timer_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              clear_c;
  logic              load_c;
  logic              win_end_c;
  logic              hs_c;
  hdr_t              hdr;

  assign hs_c      = out_valid && out_ready;
  // A timeout and a trigger in the same cycle collapse into one window end.
  assign win_end_c = enable &&
                     (((interval != 32'd0) && (timer_q == interval - 32'd1)) || sw_trigger);
  assign hdr       = '{flag: 1'b1, seq: seq_q, drop: drop_q};

  // Clear is combinational so the bank restarts in the very cycle the window closes;
  // it is held off while the block sits in reset.
  assign counter_clear = clear_c && rst_n;
  assign busy          = (state_q == SEND_HDR) || (state_q == SEND_DATA);
  assign dropped_count = drop_q;

  // State, window timer, sequence number and drop counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state, timer, clear/load strobes and drop accounting.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    seq_d   = seq_q;
    drop_d  = drop_q;
    clear_c = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (enable) begin
          state_d = COUNT;
          clear_c = 1'b1;
        end
      end
      COUNT: begin
        if (!enable) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (win_end_c) begin
          state_d = SEND_HDR;
          load_c  = 1'b1;
          clear_c = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      SEND_HDR, SEND_DATA: begin
        // Windows keep closing while a packet is in flight; those are dropped.
        if (!enable) begin
          timer_d = '0;
        end else if (win_end_c) begin
          clear_c = 1'b1;
          timer_d = '0;
          if (drop_q != '1) begin
            drop_d = drop_q + DROP_W'(1);
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
        if (hs_c) begin
          if (state_q == SEND_HDR) begin
            seq_d   = seq_q + SEQ_W'(1);
            state_d = SEND_DATA;
          end else if (out_last) begin
            state_d = enable ? COUNT : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  perf_sample_serializer #(
    .NUM_EVENTS    (NUM_EVENTS),
    .COUNTER_WIDTH (COUNTER_WIDTH),
    .OUT_WIDTH     (OUT_WIDTH)
  ) u_serializer (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load_c),
    .hdr           (hdr),
    .counters_flat (counters_flat),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_last      (out_last)
  );

endmodule

// File: tb/tb_perf_counter_sample_ctrl.sv
// Scoreboard bench for perf_counter_sample_ctrl.
module tb_perf_counter_sample_ctrl;

  localparam int unsigned NE = 115;
  localparam int unsigned CW = 7;
  localparam int unsigned OW = 32;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
    logic          hdr;
  } beat_t;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [31:0]      interval;
  logic             sw_trigger;
  logic [NE*CW-1:0] counters_flat;
  logic             counter_clear;
  logic             out_valid;
  logic             out_ready;
  logic [OW-1:0]    out_data;
  logic             out_last;
  logic             busy;
  logic [7:0]       dropped_count;

  logic [CW-1:0] cnt_v [NE];
  beat_t         exp_q [$];
  int            clr_cyc [$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            clr_cnt = 0;
  int            hdr_seen = 0;
  int            pop_cnt = 0;
  int            stall_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  perf_counter_sample_ctrl #(
    .NUM_EVENTS    (NE),
    .COUNTER_WIDTH (CW),
    .OUT_WIDTH     (OW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .interval      (interval),
    .sw_trigger    (sw_trigger),
    .counters_flat (counters_flat),
    .counter_clear (counter_clear),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .dropped_count (dropped_count)
  );

  for (genvar g = 0; g < NE; g++) begin : g_pack
    assign counters_flat[g*CW +: CW] = cnt_v[g];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input logic [CW-1:0] v);
    for (int i = 0; i < NE; i++) cnt_v[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NE; i++) cnt_v[i] = CW'($urandom);
  endtask

  // Expected packet: header {1, seq, drop} then {0, idx, value} per event.
  task automatic push_pkt(input logic [15:0] seq, input logic [7:0] drop);
    beat_t b;
    b.data = OW'({1'b1, seq, drop});
    b.last = 1'b0;
    b.hdr  = 1'b1;
    exp_q.push_back(b);
    for (int i = 0; i < NE; i++) begin
      b.data = OW'({1'b0, 7'(i), cnt_v[i]});
      b.last = (i == NE - 1);
      b.hdr  = 1'b0;
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse_trigger();
    sw_trigger = 1'b1;
    tick(1);
    sw_trigger = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int bound);
    for (int i = 0; i < bound && !out_valid; i++) tick(1);
    check_eq(tag, 64'(out_valid), 64'd1);
  endtask

  task automatic drain(input string tag, input int bound);
    for (int i = 0; i < bound && (exp_q.size() != 0 || busy); i++) tick(1);
    check_eq(tag, 64'(exp_q.size()), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Monitor: logs clears, checks stability under backpressure, scores handshakes.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (counter_clear) begin
        clr_cnt++;
        clr_cyc.push_back(cyc);
      end
      if (prev_stall) begin
        check_eq("hold_valid", 64'(out_valid), 64'd1);
        check_eq("hold_data", 64'(out_data), 64'(prev_data));
        check_eq("hold_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && out_ready) begin
        check_eq("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          pop_cnt++;
          if (e.hdr) hdr_seen++;
          check_eq(e.hdr ? "hdr_beat" : "data_beat", 64'(out_data), 64'(e.data));
          check_eq("beat_last", 64'(out_last), 64'(e.last));
        end
      end
      if (out_valid && !out_ready) stall_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int clr_base;
    int hdr_base;
    int pop_base;
    int v_cyc;

    rst_n      = 1'b0;
    enable     = 1'b0;
    interval   = 32'd0;
    sw_trigger = 1'b0;
    out_ready  = 1'b0;
    fill_const('0);
    tick(3);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_data", 64'(out_data), 64'd0);
    check_eq("rst_last", 64'(out_last), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_drop", 64'(dropped_count), 64'd0);
    check_eq("rst_clear", 64'(counter_clear), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Interval timeout: clears 10 cycles apart, valid one cycle after the window end.
    fill_const(CW'(3));
    interval  = 32'd10;
    out_ready = 1'b1;
    push_pkt(16'd0, 8'd0);
    clr_cyc.delete();
    clr_base = clr_cnt;
    enable   = 1'b1;
    wait_valid("t1_valid", 40);
    v_cyc  = cyc;
    enable = 1'b0;
    check_eq("t1_clear_count", 64'(clr_cnt - clr_base), 64'd2);
    check_eq("t1_clear_period", 64'(clr_cyc[1] - clr_cyc[0]), 64'd10);
    check_eq("t1_valid_latency", 64'(v_cyc - clr_cyc[1]), 64'd1);
    drain("t1_drain", 400);
    check_eq("t1_no_drop", 64'(dropped_count), 64'd0);
    check_eq("t1_no_more_clear", 64'(clr_cnt - clr_base), 64'd2);

    // Software trigger with the timer off: exactly one packet.
    interval = 32'd0;
    fill_rand();
    push_pkt(16'd1, 8'd0);
    hdr_base = hdr_seen;
    enable   = 1'b1;
    tick(5);
    pulse_trigger();
    fill_rand();
    tick(1000);
    check_eq("t2_one_packet", 64'(hdr_seen - hdr_base), 64'd1);
    check_eq("t2_sb_empty", 64'(exp_q.size()), 64'd0);
    check_eq("t2_idle_bus", 64'(busy), 64'd0);

    // Random backpressure.
    fill_rand();
    push_pkt(16'd2, 8'd0);
    pulse_trigger();
    fill_rand();
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || busy); i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    out_ready = 1'b1;
    drain("t3_drain", 10);
    check_eq("t3_stalls_seen", 64'(stall_cnt > 0), 64'd1);

    // Drops while the output is blocked; pending packet keeps the first snapshot.
    enable = 1'b0;
    tick(3);
    fill_rand();
    interval  = 32'd20;
    out_ready = 1'b0;
    push_pkt(16'd3, 8'd0);
    enable = 1'b1;
    wait_valid("t4_valid", 60);
    fill_rand();
    tick(50);
    check_eq("t4_dropped", 64'(dropped_count), 64'd2);
    interval  = 32'd0;
    out_ready = 1'b1;
    drain("t4_drain", 400);
    push_pkt(16'd4, 8'd2);
    pulse_trigger();
    fill_rand();
    drain("t4_next", 400);

    // Drop counter saturation.
    fill_rand();
    push_pkt(16'd5, 8'd2);
    interval  = 32'd2;
    out_ready = 1'b0;
    pulse_trigger();
    wait_valid("t5_valid", 10);
    fill_rand();
    tick(700);
    check_eq("t5_saturated", 64'(dropped_count), 64'd255);
    interval  = 32'd0;
    out_ready = 1'b1;
    drain("t5_drain", 400);

    // Sequence number wrap.
    force dut.seq_q = 16'hFFFF;
    tick(1);
    release dut.seq_q;
    tick(1);
    fill_rand();
    push_pkt(16'hFFFF, 8'd255);
    pulse_trigger();
    fill_rand();
    drain("t6_ffff", 400);
    push_pkt(16'h0000, 8'd255);
    pulse_trigger();
    fill_rand();
    drain("t6_wrap", 400);

    // Enable drops during data beat 40: packet completes, then idle with no clear.
    push_pkt(16'h0001, 8'd255);
    pop_base = pop_cnt;
    pulse_trigger();
    fill_rand();
    for (int i = 0; i < 400 && pop_cnt < pop_base + 41; i++) tick(1);
    check_eq("t7_at_beat40", 64'(out_data[14:7]), 64'd40);
    enable   = 1'b0;
    clr_base = clr_cnt;
    drain("t7_drain", 400);
    tick(30);
    check_eq("t7_no_clear", 64'(clr_cnt - clr_base), 64'd0);
    check_eq("t7_idle_valid", 64'(out_valid), 64'd0);
    check_eq("t7_idle_busy", 64'(busy), 64'd0);

    // Reset in the middle of a packet.
    enable = 1'b1;
    tick(3);
    push_pkt(16'h0002, 8'd255);
    pulse_trigger();
    tick(20);
    rst_n = 1'b0;
    #1;
    check_eq("t8_rst_valid", 64'(out_valid), 64'd0);
    check_eq("t8_rst_data", 64'(out_data), 64'd0);
    check_eq("t8_rst_last", 64'(out_last), 64'd0);
    check_eq("t8_rst_busy", 64'(busy), 64'd0);
    check_eq("t8_rst_drop", 64'(dropped_count), 64'd0);
    check_eq("t8_rst_clear", 64'(counter_clear), 64'd0);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check_eq("t8_post_valid", 64'(out_valid), 64'd0);
    fill_rand();
    push_pkt(16'd0, 8'd0);
    pulse_trigger();
    fill_rand();
    drain("t8_fresh", 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
